// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB row scanner.
//   state_t      : scanner state (IDLE, SCAN)
//   CH_R/G/B     : channel index of each colour plane in ROW_DATA / PIX_OUT
//   DEF_WIDTH    : default columns per row
//   DEF_CHANNELS : default number of colour planes
package rgb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam int unsigned CH_R = 0;
  localparam int unsigned CH_G = 1;
  localparam int unsigned CH_B = 2;

  localparam int unsigned DEF_WIDTH    = 16;
  localparam int unsigned DEF_CHANNELS = 3;

endpackage

// File: rtl/rgb_col_mux.sv
// WIDTH:1 bit selector for one colour plane of a row.
//   row_bits : row vector, column i at bit i
//   idx      : physical column to select
//   sel_bit  : row_bits[idx]; 0 when idx is out of range
module rgb_col_mux #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned COL_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] row_bits,
  input  logic [COL_W-1:0] idx,
  output logic             sel_bit
);

  // Explicit compare loop keeps non-power-of-two WIDTH safe from out-of-range indexing.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (idx == COL_W'(i)) sel_bit = row_bits[i];
    end
  end

endmodule

// File: rtl/rgb_row_scanner.sv
// Registered row scanner: buffers one active and one pending row and emits one
// column (one bit per channel) on each PIX_EN tick, in normal or mirrored order.
//   CLK, RST_N  : clock, synchronous active-low reset
//   ROW_DATA    : CHANNELS*WIDTH row bits, channel c column i at c*WIDTH+i
//   ROW_MIRROR  : scan direction for the offered row (1 = last column first)
//   ROW_VALID   : row offered
//   ROW_READY   : row can be accepted (pending slot empty, not in reset)
//   PIX_EN      : pixel tick request
//   PIX_OUT     : current pixel, bit c = channel c
//   PIX_VALID   : single-cycle pulse when PIX_OUT/COL update
//   COL         : scan position of the pixel on PIX_OUT
//   ROW_DONE    : pulses with PIX_VALID on the last pixel of a row
module rgb_row_scanner
  import rgb_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  localparam int unsigned COL_W   = $clog2(WIDTH)
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [CHANNELS*WIDTH-1:0] ROW_DATA,
  input  logic                      ROW_MIRROR,
  input  logic                      ROW_VALID,
  output logic                      ROW_READY,
  input  logic                      PIX_EN,
  output logic [CHANNELS-1:0]       PIX_OUT,
  output logic                      PIX_VALID,
  output logic [COL_W-1:0]          COL,
  output logic                      ROW_DONE
);

  state_t                      state;
  logic [CHANNELS*WIDTH-1:0]   active_row;
  logic [CHANNELS*WIDTH-1:0]   pend_row;
  logic                        act_mirror;
  logic                        pend_mirror;
  logic                        pend_full;
  logic [COL_W-1:0]            pos;
  logic [COL_W-1:0]            phys_idx;
  logic [CHANNELS-1:0]         mux_bits;
  logic                        accept;
  logic                        last_col;

  assign ROW_READY = RST_N && !pend_full;
  assign accept    = ROW_VALID && ROW_READY;
  assign last_col  = (pos == COL_W'(WIDTH - 1));
  assign phys_idx  = act_mirror ? (COL_W'(WIDTH - 1) - pos) : pos;

  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_chan
    rgb_col_mux #(
      .WIDTH (WIDTH)
    ) u_col_mux (
      .row_bits (active_row[c*WIDTH +: WIDTH]),
      .idx      (phys_idx),
      .sel_bit  (mux_bits[c])
    );
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= IDLE;
      active_row  <= '0;
      act_mirror  <= 1'b0;
      pend_row    <= '0;
      pend_mirror <= 1'b0;
      pend_full   <= 1'b0;
      pos         <= '0;
      PIX_OUT     <= '0;
      PIX_VALID   <= 1'b0;
      COL         <= '0;
      ROW_DONE    <= 1'b0;
    end else begin
      PIX_VALID <= 1'b0;
      ROW_DONE  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            active_row <= ROW_DATA;
            act_mirror <= ROW_MIRROR;
            pos        <= '0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (PIX_EN) begin
            PIX_OUT   <= mux_bits;
            COL       <= pos;
            PIX_VALID <= 1'b1;
            if (last_col) begin
              ROW_DONE <= 1'b1;
              if (pend_full) begin
                active_row <= pend_row;
                act_mirror <= pend_mirror;
                pend_full  <= 1'b0;
                pos        <= '0;
              end else if (accept) begin
                // Pending slot is empty, so a same-cycle row bypasses it.
                active_row <= ROW_DATA;
                act_mirror <= ROW_MIRROR;
                pos        <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              pos <= pos + COL_W'(1);
            end
          end
          if (accept && !(PIX_EN && last_col)) begin
            pend_row    <= ROW_DATA;
            pend_mirror <= ROW_MIRROR;
            pend_full   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_row_scanner.sv
module tb_rgb_row_scanner;
  import rgb_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned CH = 3;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [47:0]   ROW_DATA;
  logic          ROW_MIRROR;
  logic          ROW_VALID;
  logic          ROW_READY;
  logic          PIX_EN;
  logic [2:0]    PIX_OUT;
  logic          PIX_VALID;
  logic [3:0]    COL;
  logic          ROW_DONE;

  int checks = 0;
  int errors = 0;

  // Row A: R=8001, G=00FF, B=0000. Row B: B=0001 only. Row C: R=FFFF. Row D: G=FFFF, B=8000.
  localparam logic [47:0] ROW_A = {16'h0000, 16'h00FF, 16'h8001};
  localparam logic [47:0] ROW_B = {16'h0001, 16'h0000, 16'h0000};
  localparam logic [47:0] ROW_C = {16'h0000, 16'h0000, 16'hFFFF};
  localparam logic [47:0] ROW_D = {16'h8000, 16'hFFFF, 16'h0000};

  rgb_row_scanner #(
    .WIDTH    (W),
    .CHANNELS (CH)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ROW_DATA   (ROW_DATA),
    .ROW_MIRROR (ROW_MIRROR),
    .ROW_VALID  (ROW_VALID),
    .ROW_READY  (ROW_READY),
    .PIX_EN     (PIX_EN),
    .PIX_OUT    (PIX_OUT),
    .PIX_VALID  (PIX_VALID),
    .COL        (COL),
    .ROW_DONE   (ROW_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-derived pixels of row A scanned in column order.
  function automatic logic [2:0] exp_a(input int p);
    if (p == 0) return 3'b011;
    else if (p <= 7) return 3'b010;
    else if (p <= 14) return 3'b000;
    else return 3'b001;
  endfunction

  initial begin
    RST_N = 1'b0; ROW_DATA = '0; ROW_MIRROR = 1'b0; ROW_VALID = 1'b0; PIX_EN = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_pix_out", 48'(PIX_OUT), 48'd0);
    chk("rst_pix_valid", 48'(PIX_VALID), 48'd0);
    chk("rst_row_done", 48'(ROW_DONE), 48'd0);
    chk("rst_col", 48'(COL), 48'd0);
    chk("rst_ready", 48'(ROW_READY), 48'd0);
    RST_N = 1'b1;
    PIX_EN = 1'b1;
    tick();
    chk("rel_ready", 48'(ROW_READY), 48'd1);
    tick();
    chk("idle_no_valid", 48'(PIX_VALID), 48'd0);

    // Single row, normal direction
    ROW_DATA = ROW_A; ROW_MIRROR = 1'b0; ROW_VALID = 1'b1;
    tick();
    ROW_VALID = 1'b0;
    for (int p = 0; p < 16; p++) begin
      tick();
      chk($sformatf("norm_valid_%0d", p), 48'(PIX_VALID), 48'd1);
      chk($sformatf("norm_col_%0d", p), 48'(COL), 48'(p));
      chk($sformatf("norm_pix_%0d", p), 48'(PIX_OUT), 48'(exp_a(p)));
      chk($sformatf("norm_done_%0d", p), 48'(ROW_DONE), 48'(p == 15));
    end
    tick();
    chk("norm_idle_valid", 48'(PIX_VALID), 48'd0);
    chk("norm_idle_hold", 48'(PIX_OUT), 48'(3'b001));

    // Mirror
    ROW_DATA = ROW_A; ROW_MIRROR = 1'b1; ROW_VALID = 1'b1;
    tick();
    ROW_VALID = 1'b0;
    for (int p = 0; p < 16; p++) begin
      tick();
      chk($sformatf("mir_valid_%0d", p), 48'(PIX_VALID), 48'd1);
      chk($sformatf("mir_col_%0d", p), 48'(COL), 48'(p));
      chk($sformatf("mir_pix_%0d", p), 48'(PIX_OUT), 48'(exp_a(15 - p)));
    end
    tick();
    chk("mir_idle_valid", 48'(PIX_VALID), 48'd0);

    // Back-to-back: row A then mirrored row B (only its last scan pixel has B set)
    ROW_DATA = ROW_A; ROW_MIRROR = 1'b0; ROW_VALID = 1'b1;
    tick();
    ROW_VALID = 1'b0;
    for (int q = 0; q < 32; q++) begin
      tick();
      chk($sformatf("b2b_valid_%0d", q), 48'(PIX_VALID), 48'd1);
      chk($sformatf("b2b_col_%0d", q), 48'(COL), 48'(q % 16));
      chk($sformatf("b2b_pix_%0d", q), 48'(PIX_OUT),
          (q < 16) ? 48'(exp_a(q)) : ((q == 31) ? 48'(3'b100) : 48'd0));
      chk($sformatf("b2b_done_%0d", q), 48'(ROW_DONE), 48'(q == 15 || q == 31));
      chk($sformatf("b2b_ready_%0d", q), 48'(ROW_READY), 48'(!(q >= 4 && q <= 14)));
      if (q == 3) begin
        ROW_DATA = ROW_B; ROW_MIRROR = 1'b1; ROW_VALID = 1'b1;
      end else if (q == 4) begin
        ROW_VALID = 1'b0;
      end
    end
    tick();
    chk("b2b_end_valid", 48'(PIX_VALID), 48'd0);

    // Sparse ticks: one PIX_EN every 4th cycle
    PIX_EN = 1'b0;
    ROW_DATA = ROW_A; ROW_MIRROR = 1'b0; ROW_VALID = 1'b1;
    tick();
    ROW_VALID = 1'b0;
    for (int k = 0; k < 5; k++) begin
      PIX_EN = 1'b1;
      tick();
      PIX_EN = 1'b0;
      chk($sformatf("sp_valid_%0d", k), 48'(PIX_VALID), 48'd1);
      chk($sformatf("sp_col_%0d", k), 48'(COL), 48'(k));
      chk($sformatf("sp_pix_%0d", k), 48'(PIX_OUT), 48'(exp_a(k)));
      for (int h = 0; h < 3; h++) begin
        tick();
        chk($sformatf("sp_gap_valid_%0d_%0d", k, h), 48'(PIX_VALID), 48'd0);
        chk($sformatf("sp_gap_col_%0d_%0d", k, h), 48'(COL), 48'(k));
        chk($sformatf("sp_gap_pix_%0d_%0d", k, h), 48'(PIX_OUT), 48'(exp_a(k)));
      end
    end

    // Fill pending with row C while scanning on to column 7, then reset
    PIX_EN = 1'b1;
    ROW_DATA = ROW_C; ROW_MIRROR = 1'b0; ROW_VALID = 1'b1;
    tick();
    ROW_VALID = 1'b0;
    chk("mid_col5", 48'(COL), 48'd5);
    tick();
    tick();
    chk("mid_col7", 48'(COL), 48'd7);
    chk("mid_pend_full", 48'(ROW_READY), 48'd0);
    RST_N = 1'b0;
    PIX_EN = 1'b0;
    tick();
    chk("mrst_pix_out", 48'(PIX_OUT), 48'd0);
    chk("mrst_valid", 48'(PIX_VALID), 48'd0);
    chk("mrst_done", 48'(ROW_DONE), 48'd0);
    chk("mrst_col", 48'(COL), 48'd0);
    chk("mrst_ready", 48'(ROW_READY), 48'd0);
    RST_N = 1'b1;
    tick();
    chk("mrst_rel_ready", 48'(ROW_READY), 48'd1);

    // Row D after reset; pending row C must not follow it
    PIX_EN = 1'b1;
    ROW_DATA = ROW_D; ROW_MIRROR = 1'b0; ROW_VALID = 1'b1;
    tick();
    ROW_VALID = 1'b0;
    for (int p = 0; p < 16; p++) begin
      tick();
      chk($sformatf("d_valid_%0d", p), 48'(PIX_VALID), 48'd1);
      chk($sformatf("d_col_%0d", p), 48'(COL), 48'(p));
      chk($sformatf("d_pix_%0d", p), 48'(PIX_OUT), (p == 15) ? 48'(3'b110) : 48'(3'b010));
    end
    tick();
    chk("d_no_pending", 48'(PIX_VALID), 48'd0);
    chk("d_red_plane", 48'(PIX_OUT[CH_R]), 48'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_row_scanner.md
# rgb_row_scanner

Parametrised, registered row scanner for the RGB display path. It accepts a full row of pixel data for each of `CHANNELS` colour planes through a valid/ready handshake and buffers up to two rows: one active and one pending. On every pixel-enable tick it emits one column's bits, one per channel. Scan direction is selectable per row. It supersedes the fixed 16:1 combinational column selector and sits between the row-data source and the display driver.

## Interface
- `WIDTH`, default 16: columns per row; must be ≥2.
- `CHANNELS`, default 3: colour planes (0=R, 1=G, 2=B).
- `COL_W`, localparam `$clog2(WIDTH)`: column index width.

Ports:
- `CLK`, input, 1: single clock; all logic is on its rising edge.
- `RST_N`, input, 1: reset, synchronous and active-low.
- `ROW_DATA`, input, `CHANNELS*WIDTH`: channel c, column i at bit `c*WIDTH+i`.
- `ROW_MIRROR`, input, 1: scan direction for the offered row (0 = column 0 first); sampled with `ROW_DATA`.
- `ROW_VALID`, input, 1: row offered.
- `ROW_READY`, output, 1: block can accept a row.
- `PIX_EN`, input, 1: pixel tick request.
- `PIX_OUT`, output, `CHANNELS`: bit c = channel c of the current pixel.
- `PIX_VALID`, output, 1: one-cycle pulse, `PIX_OUT`/`COL` updated.
- `COL`, output, `COL_W`: scan position (0..`WIDTH-1`) of the pixel on `PIX_OUT`.
- `ROW_DONE`, output, 1: pulses with `PIX_VALID` on the last pixel of a row.

## Operation
- Storage: `active` row and mirror flag; `pending` row, mirror flag and `pend_full`.
- `ROW_READY = !pend_full`. A row is accepted on any cycle with `ROW_VALID && ROW_READY`.
- States: `IDLE` and `SCAN`.
  - `IDLE`: an accepted row loads `active`, position is set to 0, and the state goes to `SCAN`. `PIX_EN` is ignored.
  - `SCAN`: an accepted row loads `pending` and sets `pend_full`.
  - `SCAN` with `PIX_EN`: physical index = mirror ? `WIDTH-1-pos` : `pos`. `PIX_OUT[c]` is set to `active[c*WIDTH+index]`, `COL` to `pos`, and `PIX_VALID` pulses. Then `pos` increments.
- End of row (`PIX_EN` at `pos==WIDTH-1`):
  - `ROW_DONE` pulses with that pixel.
  - If `pend_full`: pending moves to active, `pend_full` clears, `pos` resets to 0, state stays `SCAN`.
  - Otherwise, if a row is accepted in the same cycle: that row goes directly to active, `pos` resets to 0, state stays `SCAN`.
  - Otherwise: state goes to `IDLE`.
- Simultaneous events:
  - Pending→active transfer and a new accept in the same cycle cannot occur, because accept requires `!pend_full`.
  - An accept in a non-end `SCAN` cycle with `PIX_EN` fills pending; the scan continues unaffected.
- No wrap-around of `pos` beyond `WIDTH-1`. `pos` wraps to 0 only via the end-of-row rule.

## Timing
- Reset (`RST_N` low at an edge):
  - `PIX_OUT=0`, `PIX_VALID=0`, `ROW_DONE=0`, `COL=0`.
  - State `IDLE`; `pend_full=0`; the pending row is discarded.
  - `ROW_READY` is 0 while `RST_N` is low and 1 from the first cycle after release.
- Reset mid-scan aborts the row immediately. No `ROW_DONE` is issued.
- Accept at edge n: `SCAN` from n+1. The first `PIX_EN` sampled at edge ≥ n+1 gives `PIX_VALID` in the following cycle.
- Pixel latency: `PIX_EN` sampled at edge k → outputs valid in cycle k+1.
- `PIX_OUT` and `COL` hold between pixels. `PIX_VALID` and `ROW_DONE` are single-cycle.
- Back-to-back rows with continuous `PIX_EN` are emitted without a bubble.
- All outputs are registered except `ROW_READY` (derived from registered `pend_full` and `RST_N`).

## Structure
- Package `rgb_pkg`:
  - state enum (`IDLE`, `SCAN`);
  - channel index constants `CH_R=0`, `CH_G=1`, `CH_B=2`;
  - default `WIDTH`/`CHANNELS`.
- Sub-module `rgb_col_mux`: parametrised `WIDTH`:1 bit selector (row vector, index → bit). It is instantiated once per channel, and its output is registered in `rgb_row_scanner`.

## Test plan
- **Reset:** hold `RST_N` low 2 cycles → all outputs 0, `ROW_READY=0`; release → `ROW_READY=1`, `PIX_VALID` stays 0 with `PIX_EN` high.
- **Single row, normal direction:** R=16'h8001, G=16'h00FF, B=16'h0000, `ROW_MIRROR=0`, `PIX_EN` constant.
  - Pixels 0–7 = 3'b011 except pixels 1–7 = 3'b010; pixels 8–14 = 3'b000; pixel 15 = 3'b001.
  - `ROW_DONE` with `COL=15`; returns to `IDLE`.
- **Mirror:** same row with `ROW_MIRROR=1`.
  - First pixel 3'b001 with `COL=0`; pixel 15 = 3'b011 with `COL=15`.
- **Back-to-back:** second row offered at `COL=3` of the first → `ROW_READY` low until transfer.
  - 32 consecutive `PIX_VALID` cycles; second row's pixel 0 immediately follows `ROW_DONE`.
- **Sparse ticks:** `PIX_EN` every 4th cycle → `PIX_VALID` exactly one cycle after each tick; `COL` and `PIX_OUT` hold between ticks.
- **Reset mid-scan:** reset at `COL=7` with pending full → outputs cleared, pending dropped.
  - Next accepted row starts at `COL=0` with its own data.
